// File: rtl/kf8088_inta_pkg.sv
// ----------------------------------------------------------------------------
// kf8088_inta_pkg
// Shared types and constants for the KF8088 interrupt-acknowledge block.
//   inta_state_t : acknowledge sequencer states
//   NMI_VECTOR   : vector byte reported for a non-maskable interrupt
//   max_u        : helper to size the pulse/gap down-counter
// ----------------------------------------------------------------------------
package kf8088_inta_pkg;

   typedef enum logic [2:0] {IDLE, PULSE1, GAP, PULSE2, HOLD} inta_state_t;

   localparam logic [7:0] NMI_VECTOR = 8'h02;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/kf8088_inta_pulse_timer.sv
// ----------------------------------------------------------------------------
// kf8088_inta_pulse_timer
// Loadable down-counter that times INTA pulse and gap widths.
//   clock      in  : sole clock
//   reset      in  : synchronous, active-high; clears the count
//   load       in  : load load_value on this edge (takes priority)
//   load_value in  : value loaded, i.e. remaining cycles minus one
//   expired    out : count has reached zero
// The counter holds at zero instead of wrapping.
// ----------------------------------------------------------------------------
module kf8088_inta_pulse_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/kf8088_interrupt_acknowledge.sv
// ----------------------------------------------------------------------------
// kf8088_interrupt_acknowledge
// CPU-side initiator of the 8259 INT/INTA handshake. Samples INT, runs the
// two-pulse locked INTA bus cycle, captures the vector byte at the end of the
// second pulse and offers it to the core over a valid/ready handshake.
//
// Parameters
//   PULSE_CYCLES : clocks each INTA pulse is held low (>=1)
//   GAP_CYCLES   : clocks INTA is high between the two pulses (>=1)
//
// Ports
//   clock                   in  : sole clock
//   reset                   in  : synchronous, active-high
//   interrupt               in  : INT from PIC, level-sensitive
//   interrupt_enable        in  : CPU IF flag
//   bus_idle                in  : no other bus cycle in progress
//   data_bus_in[7:0]        in  : PIC data bus, vector driven in pulse 2
//   interrupt_acknowledge_n out : INTA strobe, active-low
//   bus_lock                out : LOCK for the whole INTA sequence
//   acknowledge_busy        out : sequencer not idle
//   vector_valid            out : captured vector available
//   vector[7:0]             out : captured vector byte
//   vector_ready            in  : consumer accepts the vector
//   nmi                     in  : (KF_INTA_NMI_SUPPORT_EN only) NMI pin,
//                                 rising-edge triggered
//
// Configuration macro: KF_INTA_NMI_SUPPORT_EN adds the nmi input and NMI path.
// All outputs are registered and derived from the next state.
// ----------------------------------------------------------------------------
module kf8088_interrupt_acknowledge
   import kf8088_inta_pkg::*;
#(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       interrupt,
   input  logic       interrupt_enable,
   input  logic       bus_idle,
   input  logic [7:0] data_bus_in,
   output logic       interrupt_acknowledge_n,
   output logic       bus_lock,
   output logic       acknowledge_busy,
   output logic       vector_valid,
   output logic [7:0] vector,
`ifdef KF_INTA_NMI_SUPPORT_EN
   input  logic       nmi,
`endif
   input  logic       vector_ready
);

   localparam int CNT_W = $clog2(max_u(PULSE_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

   inta_state_t      state_q, state_d;
   logic             inta_n_q, inta_n_d;
   logic             lock_q, lock_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [7:0]       vector_q, vector_d;

   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_expired;

`ifdef KF_INTA_NMI_SUPPORT_EN
   logic             nmi_prev_q, nmi_prev_d;
   logic             nmi_pending_q, nmi_pending_d;
   logic             nmi_req;
   logic             nmi_service;

   // An edge seen this cycle is serviced immediately when idle; otherwise it
   // stays latched until the sequencer is back in IDLE.
   assign nmi_req = nmi_pending_q | (nmi & ~nmi_prev_q);
`endif

   kf8088_inta_pulse_timer #(
      .WIDTH(CNT_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .expired    (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      vector_d    = vector_q;
      timer_load  = 1'b0;
      timer_value = PULSE_LOAD;
`ifdef KF_INTA_NMI_SUPPORT_EN
      nmi_service = 1'b0;
      nmi_prev_d  = nmi;
`endif

      unique case (state_q)
         IDLE: begin
`ifdef KF_INTA_NMI_SUPPORT_EN
            // NMI needs no bus cycle: report the fixed vector straight away.
            if (nmi_req) begin
               state_d     = HOLD;
               vector_d    = NMI_VECTOR;
               valid_d     = 1'b1;
               nmi_service = 1'b1;
            end else
`endif
            if (interrupt && interrupt_enable && bus_idle && !valid_q) begin
               state_d     = PULSE1;
               timer_load  = 1'b1;
               timer_value = PULSE_LOAD;
            end
         end
         // Once started, the sequence ignores INT/IF so the PIC always sees
         // both pulses.
         PULSE1: begin
            if (timer_expired) begin
               state_d     = GAP;
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         GAP: begin
            if (timer_expired) begin
               state_d     = PULSE2;
               timer_load  = 1'b1;
               timer_value = PULSE_LOAD;
            end
         end
         PULSE2: begin
            if (timer_expired) begin
               state_d  = HOLD;
               vector_d = data_bus_in;
               valid_d  = 1'b1;
            end
         end
         HOLD: begin
            if (vector_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

`ifdef KF_INTA_NMI_SUPPORT_EN
      nmi_pending_d = nmi_req & ~nmi_service;
`endif

      inta_n_d = !((state_d == PULSE1) || (state_d == PULSE2));
      lock_d   = (state_d == PULSE1) || (state_d == GAP) || (state_d == PULSE2);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         inta_n_q      <= 1'b1;
         lock_q        <= 1'b0;
         busy_q        <= 1'b0;
         valid_q       <= 1'b0;
         vector_q      <= 8'h00;
`ifdef KF_INTA_NMI_SUPPORT_EN
         nmi_prev_q    <= 1'b1;
         nmi_pending_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         inta_n_q      <= inta_n_d;
         lock_q        <= lock_d;
         busy_q        <= busy_d;
         valid_q       <= valid_d;
         vector_q      <= vector_d;
`ifdef KF_INTA_NMI_SUPPORT_EN
         nmi_prev_q    <= nmi_prev_d;
         nmi_pending_q <= nmi_pending_d;
`endif
      end
   end

   assign interrupt_acknowledge_n = inta_n_q;
   assign bus_lock                = lock_q;
   assign acknowledge_busy        = busy_q;
   assign vector_valid            = valid_q;
   assign vector                  = vector_q;

endmodule

// File: tb/tb_kf8088_interrupt_acknowledge.sv
// ----------------------------------------------------------------------------
// tb_kf8088_interrupt_acknowledge
// Scoreboard bench: the stimulus process advances a behavioural model (phase
// offset since the start condition) and queues the expected per-cycle outputs
// and captured vectors; a monitor process compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_kf8088_interrupt_acknowledge;

   localparam int P = 2;
   localparam int G = 3;

   logic       clock            = 1'b0;
   logic       reset            = 1'b1;
   logic       interrupt        = 1'b0;
   logic       interrupt_enable = 1'b0;
   logic       bus_idle         = 1'b0;
   logic [7:0] data_bus_in      = 8'h00;
   logic       vector_ready     = 1'b0;
   logic       interrupt_acknowledge_n;
   logic       bus_lock;
   logic       acknowledge_busy;
   logic       vector_valid;
   logic [7:0] vector;
`ifdef KF_INTA_NMI_SUPPORT_EN
   logic       nmi = 1'b0;
`endif

   always #5 clock = ~clock;

   kf8088_interrupt_acknowledge #(
      .PULSE_CYCLES(P),
      .GAP_CYCLES  (G)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .interrupt               (interrupt),
      .interrupt_enable        (interrupt_enable),
      .bus_idle                (bus_idle),
      .data_bus_in             (data_bus_in),
      .interrupt_acknowledge_n (interrupt_acknowledge_n),
      .bus_lock                (bus_lock),
      .acknowledge_busy        (acknowledge_busy),
      .vector_valid            (vector_valid),
      .vector                  (vector),
`ifdef KF_INTA_NMI_SUPPORT_EN
      .nmi                     (nmi),
`endif
      .vector_ready            (vector_ready)
   );

   typedef struct {
      logic       inta_n;
      logic       lock;
      logic       busy;
      logic       valid;
      logic [7:0] vec;
   } exp_t;

   exp_t       ctrl_q[$];
   logic [7:0] vec_q[$];
   int         vectors     = 0;
   int         miscompares = 0;

   // Model: mode 0 = idle, 1 = in acknowledge sequence, 2 = holding vector.
   // m_t counts cycles since the start condition (1 .. 2P+G).
   int         m_mode = 0;
   int         m_t    = 0;
   logic [7:0] m_vec  = 8'h00;

   // Called just after a rising edge, while the inputs sampled at that edge
   // are still on the pins.
   task automatic model_edge();
      exp_t e;
      if (reset) begin
         m_mode = 0;
         m_vec  = 8'h00;
         vec_q.delete();
      end else begin
         case (m_mode)
            0: if (interrupt && interrupt_enable && bus_idle) begin
                  m_mode = 1;
                  m_t    = 1;
               end
            1: if (m_t == 2*P + G) begin
                  m_vec = data_bus_in;
                  vec_q.push_back(data_bus_in);
                  m_mode = 2;
               end else begin
                  m_t++;
               end
            default: if (vector_ready) m_mode = 0;
         endcase
      end
      e.inta_n = !(m_mode == 1 && (m_t <= P || m_t > P + G));
      e.lock   = (m_mode == 1);
      e.busy   = (m_mode != 0);
      e.valid  = (m_mode == 2);
      e.vec    = m_vec;
      ctrl_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic i, input logic e, input logic b,
                       input logic [7:0] d, input logic rd);
      @(posedge clock);
      #1;
      model_edge();
      reset            = r;
      interrupt        = i;
      interrupt_enable = e;
      bus_idle         = b;
      data_bus_in      = d;
      vector_ready     = rd;
   endtask

   // Monitor
   initial begin
      exp_t       e;
      logic [7:0] v;
      forever begin
         @(negedge clock);
         if (ctrl_q.size() > 0) begin
            e = ctrl_q.pop_front();
            vectors++;
            if (interrupt_acknowledge_n !== e.inta_n || bus_lock !== e.lock ||
                acknowledge_busy !== e.busy || vector_valid !== e.valid || vector !== e.vec) begin
               miscompares++;
               $display("FAIL outputs t=%0t got inta_n=%b lock=%b busy=%b valid=%b vec=%h expected inta_n=%b lock=%b busy=%b valid=%b vec=%h",
                        $time, interrupt_acknowledge_n, bus_lock, acknowledge_busy, vector_valid, vector,
                        e.inta_n, e.lock, e.busy, e.valid, e.vec);
            end
         end
         if (vector_valid === 1'b1 && vector_ready && !reset) begin
            vectors++;
            if (vec_q.size() == 0) begin
               miscompares++;
               $display("FAIL handshake t=%0t got vector=%h expected no vector pending", $time, vector);
            end else begin
               v = vec_q.pop_front();
               if (vector !== v) begin
                  miscompares++;
                  $display("FAIL handshake t=%0t got vector=%h expected %h", $time, vector, v);
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      repeat (3) step(1, 0, 0, 0, 8'h00, 0);
      // INT with IF low, then with the bus busy: no acknowledge may start.
      repeat (20) step(0, 1, 0, 1, 8'h55, 1);
      repeat (20) step(0, 1, 1, 0, 8'h55, 1);
      // Basic sequence with PIC vector 0x0A; consumer stalls, then accepts.
      repeat (20) step(0, 1, 1, 1, 8'h0A, 0);
      repeat (12) step(0, 1, 1, 1, 8'h0A, 1);
      // Settle idle, then INT drops right after the start.
      repeat (4) step(0, 0, 1, 1, 8'h00, 1);
      step(0, 1, 1, 1, 8'h0F, 0);
      repeat (12) step(0, 0, 0, 1, 8'h0F, 0);
      repeat (3) step(0, 0, 1, 1, 8'h0F, 1);
      // Reset while the second pulse is in progress.
      step(0, 1, 1, 1, 8'h33, 1);
      repeat (6) step(0, 0, 1, 1, 8'h33, 1);
      step(1, 0, 1, 1, 8'h33, 1);
      repeat (4) step(0, 0, 1, 1, 8'h00, 1);
      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 80),
              8'($urandom),
              ($urandom_range(0, 99) < 40));
      end
      step(0, 0, 0, 1, 8'h00, 1);
      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
